sprite_locator: RTL and testbench
=================================

# sprite_locator

Pixel-to-sprite resolver that drives the VGA output stage's sprite select and in-sprite coordinates. For each requested `(row_addr, col_addr)` it returns the sprite type, the in-sprite row/column offset and the colour mask. It resolves against a double-buffered sprite table written by game logic through a valid/ready port. The shadow table is copied to the active table only at a frame boundary, so a frame never shows a half-updated scene.

## Interface
Parameters:
- `N_SPRITES`, 8: table entries; index width `IW = $clog2(N_SPRITES)`.
- `BG_TYPE`, 6'd0: type reported where no sprite hits.
- `TILE_LOG2`, 5: background tile size is 2^TILE_LOG2 pixels square.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `row_addr` in 9: requested pixel row, 0..479 visible.
- `col_addr` in 10: requested pixel column, 0..639 visible.
- `vs` in 1: vertical sync, active-low; its falling edge marks the frame boundary.
- `wr_valid` in 1: table write request.
- `wr_ready` out 1: write accepted when `wr_valid & wr_ready`.
- `wr_idx` in IW: entry index.
- `wr_en` in 1: entry enable.
- `wr_type` in 6: sprite type.
- `wr_x` in 10, `wr_y` in 9: top-left position.
- `wr_w` in 11, `wr_h` in 11: sprite size.
- `wr_flip` in 1: horizontal mirror.
- `commit` in 1: pulse requesting a shadow-to-active copy.
- `commit_done` out 1: one-cycle pulse after the copy.
- `type` out 6, `h` out 11, `w` out 11: sprite id and in-sprite row/column.
- `mask` out 13: 13'h1FFF while visible, otherwise 0.

## Operation
- Shadow table: N entries {en, type, x, y, w, h, flip}. It is written on each accepted handshake.
- Commit handling:
  - `commit` sets `pending`. While `pending` is set, `wr_ready` = 0.
  - A further `commit` while `pending` is set is absorbed.
- Frame edge: `vs` is registered, and an edge is `vs_q & ~vs`.
  - On an edge with `pending` set, all shadow entries copy to active, `pending` clears, and `commit_done` pulses next cycle.
- Hit test for entry i, using 11-bit unsigned arithmetic with no wrap:
  - hit requires `en`.
  - Column in range: `col >= x` and `col < x+w`.
  - Row in range: `row >= y` and `row < y+h`.
  - Entries with `w` = 0 or `h` = 0 never hit.
- Priority: the lowest index hit wins.
  - On a winning hit: `type` = entry type, `h` = row−y, `w` = col−x.
  - On no hit: `type` = BG_TYPE, `h` = row mod 2^TILE_LOG2, `w` = col mod 2^TILE_LOG2.
- `mask` = 13'h1FFF when row < 480 and col < 640, otherwise 0 (type/h/w still computed).
- Simultaneous events, same cycle:
  - Accepted write and `commit`: the write lands in shadow first and is included in the commit.
  - `commit` and frame edge: the copy happens on that edge and includes that cycle's write.
- Reset:
  - All shadow and active `en` = 0, `pending` = 0, `vs_q` = 1.
  - Outputs: `wr_ready` = 1, `commit_done` = 0, `type` = 0, `h` = 0, `w` = 0, `mask` = 0, pipeline registers cleared.
  - A mid-frame reset discards any pending commit and blanks the table immediately.

## Timing
- Lookup latency is 2 cycles:
  - Stage 1 registers row/col and computes per-entry hits and offsets.
  - Stage 2 registers the priority-selected result.
- The active table changes only on the edge cycle; results for pixels in flight use the table sampled at stage 1.
- `wr_ready` falls the cycle after `commit` is sampled and rises the cycle after the copy.
- Throughput: one pixel per cycle, no stalls.

## Configuration
- `SPRITE_FLIP_EN` defined:
  - The `flip` bit is stored per entry.
  - When a flipped entry wins, `w` = (entry w − 1) − (col − x).
- Undefined:
  - `wr_flip` is still a port but is ignored.
  - No flip storage; `w` is always col − x.

## Structure
- Package `sprite_pkg`:
  - `sprite_entry_t` typedef.
  - `SCREEN_W` = 640, `SCREEN_H` = 480, `MASK_ON` = 13'h1FFF.
  - Default `N_SPRITES`.
- Sub-module `sprite_hit`, instantiated N times: the combinational per-entry range compare plus offset (and flip) computation.
- The top holds the tables, commit FSM (IDLE/PENDING), pipeline and priority mux.

## Test plan
- Reset, then sweep pixels (0,0), (479,639) and (500,700):
  - type=BG_TYPE, h/w = coordinates mod 32.
  - mask = 1FFF, 1FFF, 0, each 2 cycles after input.
- Write entry 0 {en, type=5, x=100, y=200, w=16, h=16}, commit, pulse `vs` low:
  - Before the edge, (205,110) gives BG.
  - After `commit_done`, (205,110) gives type=5, h=5, w=10.
  - (216,110) and (205,116) give BG.
- Entries 1 (type=3) and 4 (type=7) overlap at (50,50): type=3 is returned. Disabling entry 1 and committing returns type=7.
- Commit pending: `wr_ready` = 0 and a write attempt is not accepted. The edge restores `wr_ready` = 1 on the following cycle.
- Write and commit in the same cycle as the `vs` edge: the new entry is visible immediately after that edge. Reset asserted while pending: no `commit_done` and the table is all-BG.
- With `SPRITE_FLIP_EN`, entry {x=100, w=16, flip}: col 100 gives w=15, col 115 gives w=0. Without the macro: w=0 and w=15 respectively.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite locator.
// The flip field exists only when SPRITE_FLIP_EN is defined.
package sprite_pkg;

  localparam int          DEF_N_SPRITES = 8;
  localparam int          SCREEN_W      = 640;
  localparam int          SCREEN_H      = 480;
  localparam logic [12:0] MASK_ON       = 13'h1FFF;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_state_t;

  typedef struct packed {
    logic        en;
    logic [5:0]  kind;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [10:0] w;
    logic [10:0] h;
`ifdef SPRITE_FLIP_EN
    logic        flip;
`endif
  } sprite_entry_t;

endpackage

// File: rtl/sprite_hit.sv
// Combinational hit test and in-sprite offset for one table entry.
// Mirrored column offset is produced only when SPRITE_FLIP_EN is defined.
module sprite_hit
  import sprite_pkg::*;
(
  input  sprite_entry_t entry,
  input  logic [8:0]    row,
  input  logic [9:0]    col,
  output logic          hit,
  output logic [5:0]    kind,
  output logic [10:0]   off_h,
  output logic [10:0]   off_w
);

  logic [10:0] row_w;
  logic [10:0] col_w;
  logic [10:0] dy;
  logic [10:0] dx;
  logic        row_in;
  logic        col_in;

  assign row_w = {2'b00, row};
  assign col_w = {1'b0, col};
  assign dy    = row_w - {2'b00, entry.y};
  assign dx    = col_w - {1'b0, entry.x};

  // Comparing the offset against the size sidesteps the carry out of x+w,
  // and a zero size can never satisfy the strict compare.
  assign col_in = (col_w >= {1'b0, entry.x}) && (dx < entry.w);
  assign row_in = (row_w >= {2'b00, entry.y}) && (dy < entry.h);

  assign hit   = entry.en && col_in && row_in;
  assign kind  = entry.kind;
  assign off_h = dy;

`ifdef SPRITE_FLIP_EN
  assign off_w = entry.flip ? (entry.w - 11'd1 - dx) : dx;
`else
  assign off_w = dx;
`endif

endmodule

// File: rtl/sprite_locator.sv
// Pixel-to-sprite resolver: double-buffered sprite table, frame-synchronous commit, 2-cycle lookup.
// Define SPRITE_FLIP_EN to store and honour the per-entry horizontal mirror bit.
// The sprite type output is named sprite_type because `type` is a reserved word.
module sprite_locator
  import sprite_pkg::*;
#(
  parameter int         N_SPRITES = DEF_N_SPRITES,
  parameter logic [5:0] BG_TYPE   = 6'd0,
  parameter int         TILE_LOG2 = 5,
  localparam int        IW        = $clog2(N_SPRITES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [8:0]    row_addr,
  input  logic [9:0]    col_addr,
  input  logic          vs,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_en,
  input  logic [5:0]    wr_type,
  input  logic [9:0]    wr_x,
  input  logic [8:0]    wr_y,
  input  logic [10:0]   wr_w,
  input  logic [10:0]   wr_h,
  input  logic          wr_flip,
  input  logic          commit,
  output logic          commit_done,
  output logic [5:0]    sprite_type,
  output logic [10:0]   h,
  output logic [10:0]   w,
  output logic [12:0]   mask
);

  localparam logic [10:0] TILE_MASK = 11'((1 << TILE_LOG2) - 1);

  sprite_entry_t shadow      [N_SPRITES];
  sprite_entry_t shadow_next [N_SPRITES];
  sprite_entry_t active      [N_SPRITES];
  sprite_entry_t wr_entry;

  commit_state_t state;
  logic          vs_q;
  logic          frame_edge;
  logic          wr_fire;
  logic          do_copy;

  assign wr_fire    = wr_valid & wr_ready;
  assign frame_edge = vs_q & ~vs;
  // A commit arriving on the edge cycle is honoured on that same edge.
  assign do_copy    = frame_edge & ((state == ST_PENDING) | commit);

`ifdef SPRITE_FLIP_EN
  assign wr_entry = '{en: wr_en, kind: wr_type, x: wr_x, y: wr_y, w: wr_w, h: wr_h, flip: wr_flip};
`else
  logic flip_unused;
  assign flip_unused = wr_flip;
  assign wr_entry = '{en: wr_en, kind: wr_type, x: wr_x, y: wr_y, w: wr_w, h: wr_h};
`endif

  always_comb begin
    // NOTE: assigning a full default first keeps this block free of inferred latches.
    shadow_next = shadow;
    if (wr_fire) shadow_next[wr_idx] = wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the enable bits are reset; the other fields are don't-care while disabled,
      // so the tables remain plain storage without a reset on every bit.
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow[i].en <= 1'b0;
        active[i].en <= 1'b0;
      end
    end else begin
      shadow <= shadow_next;
      if (do_copy) active <= shadow_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      vs_q        <= 1'b1;
      wr_ready    <= 1'b1;
      commit_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge values, independent of statement order.
      vs_q        <= vs;
      commit_done <= do_copy;
      case (state)
        ST_IDLE: begin
          if (commit && !do_copy) begin
            state    <= ST_PENDING;
            wr_ready <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (do_copy) begin
            state    <= ST_IDLE;
            wr_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

  logic [N_SPRITES-1:0] hit_c;
  logic [N_SPRITES-1:0] hit_q;
  logic [5:0]           kind_c  [N_SPRITES];
  logic [5:0]           kind_q  [N_SPRITES];
  logic [10:0]          off_h_c [N_SPRITES];
  logic [10:0]          off_h_q [N_SPRITES];
  logic [10:0]          off_w_c [N_SPRITES];
  logic [10:0]          off_w_q [N_SPRITES];
  logic [8:0]           row_q;
  logic [9:0]           col_q;
  logic                 vis_c;
  logic                 vis_q;

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
    sprite_hit u_hit (
      .entry (active[g]),
      .row   (row_addr),
      .col   (col_addr),
      .hit   (hit_c[g]),
      .kind  (kind_c[g]),
      .off_h (off_h_c[g]),
      .off_w (off_w_c[g])
    );
  end

  assign vis_c = (int'(row_addr) < SCREEN_H) && (int'(col_addr) < SCREEN_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
      row_q <= '0;
      col_q <= '0;
      vis_q <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        kind_q[i]  <= '0;
        off_h_q[i] <= '0;
        off_w_q[i] <= '0;
      end
    end else begin
      hit_q   <= hit_c;
      kind_q  <= kind_c;
      off_h_q <= off_h_c;
      off_w_q <= off_w_c;
      row_q   <= row_addr;
      col_q   <= col_addr;
      vis_q   <= vis_c;
    end
  end

  logic [5:0]  sel_type;
  logic [10:0] sel_h;
  logic [10:0] sel_w;

  // Scanning from the top index down leaves the lowest-index hit in place.
  always_comb begin
    sel_type = BG_TYPE;
    sel_h    = {2'b00, row_q} & TILE_MASK;
    sel_w    = {1'b0, col_q} & TILE_MASK;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        sel_type = kind_q[i];
        sel_h    = off_h_q[i];
        sel_w    = off_w_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sprite_type <= '0;
      h           <= '0;
      w           <= '0;
      mask        <= '0;
    end else begin
      sprite_type <= sel_type;
      h           <= sel_h;
      w           <= sel_w;
      mask        <= vis_q ? MASK_ON : 13'h0000;
    end
  end

endmodule

// File: tb/tb_sprite_locator.sv
// Self-checking bench for sprite_locator: directed scenarios plus randomized tables and pixels
// against a behavioural model of the shadow/active tables. Honours SPRITE_FLIP_EN like the RTL.
module tb_sprite_locator;

  localparam int N  = 8;
  localparam int BG = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        vs;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_idx;
  logic        wr_en;
  logic [5:0]  wr_type;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [10:0] wr_w;
  logic [10:0] wr_h;
  logic        wr_flip;
  logic        commit;
  logic        commit_done;
  logic [5:0]  sprite_type;
  logic [10:0] h;
  logic [10:0] w;
  logic [12:0] mask;

  sprite_locator dut (
    .clk         (clk),
    .rst         (rst),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .vs          (vs),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_en       (wr_en),
    .wr_type     (wr_type),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_w        (wr_w),
    .wr_h        (wr_h),
    .wr_flip     (wr_flip),
    .commit      (commit),
    .commit_done (commit_done),
    .sprite_type (sprite_type),
    .h           (h),
    .w           (w),
    .mask        (mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en;
    int kind;
    int x;
    int y;
    int w;
    int h;
    bit flip;
  } ent_t;

  ent_t m_sh  [N];
  ent_t m_act [N];
  bit   m_pending;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_sh[i].en  = 1'b0;
      m_act[i].en = 1'b0;
    end
    m_pending = 1'b0;
  endfunction

  // First enabled entry whose rectangle contains the pixel wins; otherwise background tile coordinates.
  function automatic void model_lookup(input int r, input int c, output int t, output int hh,
                                       output int ww, output int mm);
    bit found = 1'b0;
    t  = BG;
    hh = r % 32;
    ww = c % 32;
    for (int i = 0; i < N; i++) begin
      if (!found && m_act[i].en &&
          c >= m_act[i].x && c < m_act[i].x + m_act[i].w &&
          r >= m_act[i].y && r < m_act[i].y + m_act[i].h) begin
        found = 1'b1;
        t  = m_act[i].kind;
        hh = r - m_act[i].y;
        ww = c - m_act[i].x;
`ifdef SPRITE_FLIP_EN
        if (m_act[i].flip) ww = m_act[i].w - 1 - (c - m_act[i].x);
`endif
      end
    end
    mm = (r < 480 && c < 640) ? 'h1FFF : 0;
  endfunction

  task automatic drive_fields(input int idx, input bit en, input int kind, input int x, input int y,
                              input int ww, input int hh, input bit flip);
    wr_idx  = 3'(idx);
    wr_en   = en;
    wr_type = 6'(kind);
    wr_x    = 10'(x);
    wr_y    = 9'(y);
    wr_w    = 11'(ww);
    wr_h    = 11'(hh);
    wr_flip = flip;
  endtask

  function automatic void model_write(input int idx, input bit en, input int kind, input int x,
                                      input int y, input int ww, input int hh, input bit flip);
    m_sh[idx] = '{en: en, kind: kind, x: x, y: y, w: ww, h: hh, flip: flip};
  endfunction

  task automatic lookup(input string name, input int r, input int c);
    int t, hh, ww, mm;
    model_lookup(r, c, t, hh, ww, mm);
    @(negedge clk);
    row_addr = 9'(r);
    col_addr = 10'(c);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sprite_type !== 6'(t) || h !== 11'(hh) || w !== 11'(ww) || mask !== 13'(mm)) begin
      n_fail++;
      $display("FAIL %s (%0d,%0d): got type=%0d h=%0d w=%0d mask=%h, expected type=%0d h=%0d w=%0d mask=%h",
               name, r, c, sprite_type, h, w, mask, t, hh, ww, mm);
    end
  endtask

  task automatic write_entry(input string name, input int idx, input bit en, input int kind,
                             input int x, input int y, input int ww, input int hh, input bit flip);
    bit exp_ready = !m_pending;
    @(negedge clk);
    n_checks++;
    if (wr_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL %s wr_ready: got %b, expected %b", name, wr_ready, exp_ready);
    end
    wr_valid = 1'b1;
    drive_fields(idx, en, kind, x, y, ww, hh, flip);
    @(negedge clk);
    wr_valid = 1'b0;
    if (exp_ready) model_write(idx, en, kind, x, y, ww, hh, flip);
  endtask

  task automatic commit_pulse();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    m_pending = 1'b1;
  endtask

  task automatic pulse_vs(input string name);
    bit exp_done = m_pending;
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
    vs = 1'b1;
    if (m_pending) begin
      m_act     = m_sh;
      m_pending = 1'b0;
    end
    n_checks++;
    if (commit_done !== exp_done) begin
      n_fail++;
      $display("FAIL %s commit_done after edge: got %b, expected %b", name, commit_done, exp_done);
    end
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wr_ready after edge: got %b, expected 1", name, wr_ready);
    end
    @(negedge clk);
    n_checks++;
    if (commit_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s commit_done second cycle: got %b, expected 0", name, commit_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    n_checks++;
    if (sprite_type !== 6'd0 || h !== 11'd0 || w !== 11'd0 || mask !== 13'd0 ||
        wr_ready !== 1'b1 || commit_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got type=%0d h=%0d w=%0d mask=%h wr_ready=%b commit_done=%b, expected all 0 except wr_ready=1",
               sprite_type, h, w, mask, wr_ready, commit_done);
    end
    rst = 1'b0;
    lookup("sweep_origin", 0, 0);
    lookup("sweep_last_visible", 479, 639);
    lookup("sweep_offscreen", 500, 700);
  endtask

  task automatic test_single_entry();
    write_entry("entry0_write", 0, 1'b1, 5, 100, 200, 16, 16, 1'b0);
    commit_pulse();
    lookup("entry0_before_edge", 205, 110);
    pulse_vs("entry0_commit");
    lookup("entry0_hit", 205, 110);
    lookup("entry0_row_past_end", 216, 110);
    lookup("entry0_col_past_end", 205, 116);
    lookup("entry0_top_left", 200, 100);
    lookup("entry0_bottom_right", 215, 115);
  endtask

  task automatic test_priority();
    write_entry("prio_entry1", 1, 1'b1, 3, 40, 40, 20, 20, 1'b0);
    write_entry("prio_entry4", 4, 1'b1, 7, 45, 45, 30, 30, 1'b0);
    commit_pulse();
    pulse_vs("prio_commit");
    lookup("prio_low_index_wins", 50, 50);
    write_entry("prio_disable1", 1, 1'b0, 3, 40, 40, 20, 20, 1'b0);
    commit_pulse();
    pulse_vs("prio_commit2");
    lookup("prio_entry4_after_disable", 50, 50);
  endtask

  task automatic test_pending();
    write_entry("pend_entry7", 7, 1'b1, 20, 300, 100, 8, 8, 1'b0);
    commit_pulse();
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_ready_low: got %b, expected 0", wr_ready);
    end
    write_entry("pend_rejected_write", 6, 1'b1, 21, 320, 100, 8, 8, 1'b0);
    commit_pulse();
    lookup("pend_not_yet_visible", 104, 304);
    pulse_vs("pend_commit");
    lookup("pend_entry7_visible", 104, 304);
    lookup("pend_rejected_absent", 104, 324);
  endtask

  task automatic test_same_cycle_edge();
    bit exp_acc = !m_pending;
    @(negedge clk);
    wr_valid = 1'b1;
    drive_fields(6, 1'b1, 14, 500, 10, 20, 20, 1'b0);
    commit = 1'b1;
    vs     = 1'b0;
    @(negedge clk);
    wr_valid = 1'b0;
    commit   = 1'b0;
    vs       = 1'b1;
    if (exp_acc) model_write(6, 1'b1, 14, 500, 10, 20, 20, 1'b0);
    m_act     = m_sh;
    m_pending = 1'b0;
    n_checks++;
    if (commit_done !== 1'b1 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_commit: got commit_done=%b wr_ready=%b, expected 1 1", commit_done, wr_ready);
    end
    lookup("same_cycle_entry_visible", 15, 505);
  endtask

  task automatic test_reset_pending();
    write_entry("rstp_entry2", 2, 1'b1, 12, 20, 20, 10, 10, 1'b0);
    commit_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstp_ready: got %b, expected 1", wr_ready);
    end
    pulse_vs("rstp_no_commit");
    lookup("rstp_new_entry_absent", 25, 25);
    lookup("rstp_old_entry_blanked", 205, 110);
  endtask

  task automatic test_flip_and_zero_size();
    write_entry("flip_entry2", 2, 1'b1, 9, 100, 300, 16, 8, 1'b1);
    write_entry("zero_w_entry5", 5, 1'b1, 11, 400, 400, 0, 10, 1'b0);
    write_entry("zero_h_entry3", 3, 1'b1, 13, 600, 50, 10, 0, 1'b0);
    commit_pulse();
    pulse_vs("flip_commit");
    lookup("flip_left_col", 300, 100);
    lookup("flip_right_col", 300, 115);
    lookup("flip_past_end", 300, 116);
    lookup("zero_width_no_hit", 402, 400);
    lookup("zero_height_no_hit", 50, 605);
  endtask

  task automatic test_back_to_back(input string name, input int n);
    int qr[$], qc[$], qt[$], qh[$], qw[$], qm[$];
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        int r, c, t, hh, ww, mm;
        r  = qr.pop_front();
        c  = qc.pop_front();
        t  = qt.pop_front();
        hh = qh.pop_front();
        ww = qw.pop_front();
        mm = qm.pop_front();
        n_checks++;
        if (sprite_type !== 6'(t) || h !== 11'(hh) || w !== 11'(ww) || mask !== 13'(mm)) begin
          n_fail++;
          $display("FAIL %s (%0d,%0d): got type=%0d h=%0d w=%0d mask=%h, expected type=%0d h=%0d w=%0d mask=%h",
                   name, r, c, sprite_type, h, w, mask, t, hh, ww, mm);
        end
      end
      if (k < n) begin
        int r, c, t, hh, ww, mm;
        r = $urandom_range(0, 511);
        c = $urandom_range(0, 1023);
        model_lookup(r, c, t, hh, ww, mm);
        qr.push_back(r);
        qc.push_back(c);
        qt.push_back(t);
        qh.push_back(hh);
        qw.push_back(ww);
        qm.push_back(mm);
        row_addr = 9'(r);
        col_addr = 10'(c);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 4; k++) begin
        write_entry("rand_write", $urandom_range(0, N - 1), ($urandom_range(0, 3) != 0),
                    $urandom_range(1, 63), $urandom_range(0, 1023), $urandom_range(0, 511),
                    $urandom_range(0, 400), $urandom_range(0, 300), $urandom_range(0, 1) == 1);
      end
      commit_pulse();
      pulse_vs("rand_commit");
      test_back_to_back("rand_pixel", 30);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    row_addr = '0;
    col_addr = '0;
    vs       = 1'b1;
    wr_valid = 1'b0;
    commit   = 1'b0;
    drive_fields(0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    model_reset();

    test_reset();
    test_single_entry();
    test_priority();
    test_pending();
    test_same_cycle_edge();
    test_reset_pending();
    test_flip_and_zero_size();
    test_back_to_back("b2b_pixel", 20);
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
